// File: rtl/updown_sweep_ctrl.sv
// updown_sweep_ctrl
//
// Sequencer for an external up/down counter. It takes sweep commands over a
// valid/ready handshake and drives the counter's step strobe, direction and
// clear lines. It also keeps a local mirror of the counter value, so it can
// apply wrap/saturate limits without reading the counter back.
//
// Ports:
//   clk          in   single clock, all state on posedge
//   reset        in   synchronous, active-high; overrides everything
//   cmd_valid    in   command present
//   cmd_ready    out  command can be accepted (idle only)
//   cmd_dir      in   1 = count up, 0 = count down
//   cmd_steps    in   number of steps to issue (0 = none)
//   cmd_wrap     in   1 = wrap at max/0, 0 = saturate and stop
//   cmd_clear    in   clear the counter; dir/steps/wrap ignored
//   abort        in   stop a running sweep; ignored outside the run state
//   ctr_en       out  step strobe, one counter step per high cycle
//   ctr_up_down  out  step direction, valid while ctr_en is high
//   ctr_clr      out  one-cycle clear pulse to the counter
//   count        out  mirror of the counter value
//   busy         out  high while a command is in progress
//   done         out  one-cycle pulse closing every accepted command
//   limit_hit    out  with done: a saturating sweep stopped at a limit

module updown_sweep_ctrl #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [LEN_W-1:0] cmd_steps,
  input  logic             cmd_wrap,
  input  logic             cmd_clear,
  input  logic             abort,
  output logic             ctr_en,
  output logic             ctr_up_down,
  output logic             ctr_clr,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             limit_hit
);

  localparam logic [WIDTH-1:0] CountMax = '1;
  localparam logic [WIDTH-1:0] CountOne = WIDTH'(1);
  localparam logic [LEN_W-1:0] StepsOne = LEN_W'(1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StClr,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic             dir_q, dir_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             limit_q, limit_d;

  logic accept;
  logic blocked;
  logic step;

  assign accept = cmd_valid && (state_q == StIdle);

  // A saturating sweep refuses to step past either end; it stops instead.
  assign blocked = !wrap_q && (dir_q ? (count_q == CountMax) : (count_q == '0));

  // abort wins over blocked, and both suppress the step in that cycle.
  assign step = (state_q == StRun) && !abort && !blocked;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      dir_q       <= 1'b1;
      wrap_q      <= 1'b0;
      count_q     <= '0;
      limit_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      dir_q       <= dir_d;
      wrap_q      <= wrap_d;
      count_q     <= count_d;
      limit_q     <= limit_d;
    end
  end

  // Next state and datapath
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    dir_d       = dir_q;
    wrap_d      = wrap_q;
    count_d     = count_q;
    limit_d     = limit_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          limit_d = 1'b0;
          if (cmd_clear) begin
            // A clear leaves dir/wrap alone so ctr_up_down keeps its last value.
            state_d = StClr;
          end else begin
            dir_d       = cmd_dir;
            wrap_d      = cmd_wrap;
            remaining_d = cmd_steps;
            state_d     = (cmd_steps == '0) ? StDone : StRun;
          end
        end
      end

      StRun: begin
        if (abort) begin
          state_d = StDone;
        end else if (blocked) begin
          limit_d = 1'b1;
          state_d = StDone;
        end else begin
          // Step: the counter moves on this edge, so the mirror moves with it.
          count_d     = dir_q ? (count_q + CountOne) : (count_q - CountOne);
          remaining_d = remaining_q - StepsOne;
          if (remaining_q == StepsOne) begin
            state_d = StDone;
          end
        end
      end

      StClr: begin
        count_d = '0;
        state_d = StDone;
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs
  always_comb begin
    cmd_ready   = (state_q == StIdle);
    ctr_en      = step;
    ctr_up_down = dir_q;
    ctr_clr     = (state_q == StClr);
    count       = count_q;
    busy        = (state_q != StIdle);
    done        = (state_q == StDone);
    limit_hit   = (state_q == StDone) && limit_q;
  end

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
module tb_updown_sweep_ctrl;

  localparam int unsigned WIDTH = 3;
  localparam int unsigned LEN_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_dir;
  logic [LEN_W-1:0] cmd_steps;
  logic             cmd_wrap;
  logic             cmd_clear;
  logic             abort;
  logic             ctr_en;
  logic             ctr_up_down;
  logic             ctr_clr;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             limit_hit;

  int checks = 0;
  int errors = 0;

  updown_sweep_ctrl #(
    .WIDTH(WIDTH),
    .LEN_W(LEN_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_dir    (cmd_dir),
    .cmd_steps  (cmd_steps),
    .cmd_wrap   (cmd_wrap),
    .cmd_clear  (cmd_clear),
    .abort      (abort),
    .ctr_en     (ctr_en),
    .ctr_up_down(ctr_up_down),
    .ctr_clr    (ctr_clr),
    .count      (count),
    .busy       (busy),
    .done       (done),
    .limit_hit  (limit_hit)
  );

  always #5 clk = ~clk;

  // All stimulus changes and samples happen 1 time unit after a rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Present a command for exactly one edge; returns in the cycle after accept.
  task automatic send_cmd(input logic d, input logic [LEN_W-1:0] s, input logic w,
                          input logic c);
    cmd_valid = 1'b1;
    cmd_dir   = d;
    cmd_steps = s;
    cmd_wrap  = w;
    cmd_clear = c;
    next_cycle();
    cmd_valid = 1'b0;
    cmd_clear = 1'b0;
  endtask

  // Walk cycles until done is seen; returns in the done cycle.
  task automatic run_to_done(output int en_cnt, output int cyc, output logic lim,
                             output logic timed_out);
    en_cnt    = 0;
    cyc       = 0;
    lim       = 1'b0;
    timed_out = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (done === 1'b1) begin
        lim       = limit_hit;
        timed_out = 1'b0;
        break;
      end
      if (ctr_en === 1'b1) en_cnt++;
      cyc++;
      next_cycle();
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_dir   = 1'b0;
    cmd_steps = '0;
    cmd_wrap  = 1'b0;
    cmd_clear = 1'b0;
    abort     = 1'b0;
    next_cycle();
    next_cycle();
    reset = 1'b0;
    checks++;
    if ({cmd_ready, ctr_en, ctr_up_down, ctr_clr, busy, done, limit_hit} !== 7'b1010000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 1010000",
               {cmd_ready, ctr_en, ctr_up_down, ctr_clr, busy, done, limit_hit});
    end
    checks++;
    if (count !== 3'd0) begin
      errors++;
      $display("FAIL reset_count: got %0d want 0", count);
    end
  endtask

  task automatic test_up_wrap();
    int en_cnt, cyc;
    logic lim, to;
    send_cmd(1'b1, 8'd5, 1'b1, 1'b0);
    checks++;
    if (ctr_en !== 1'b1 || ctr_up_down !== 1'b1 || busy !== 1'b1 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL up5_first_cycle: en=%b ud=%b busy=%b rdy=%b want 1 1 1 0",
               ctr_en, ctr_up_down, busy, cmd_ready);
    end
    run_to_done(en_cnt, cyc, lim, to);
    checks++;
    if (to || en_cnt != 5 || cyc != 5 || lim !== 1'b0) begin
      errors++;
      $display("FAIL up5_run: to=%b en=%0d cyc=%0d lim=%b want 0 5 5 0", to, en_cnt, cyc, lim);
    end
    checks++;
    if (count !== 3'd5 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL up5_done: count=%0d rdy=%b want 5 0", count, cmd_ready);
    end
    next_cycle();
    checks++;
    if (done !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL up5_idle: done=%b rdy=%b busy=%b want 0 1 0", done, cmd_ready, busy);
    end
  endtask

  task automatic test_wrap_around();
    int en_cnt, cyc;
    logic lim, to;
    send_cmd(1'b1, 8'd4, 1'b1, 1'b0);
    next_cycle();
    next_cycle();
    // Two steps taken from 5: mirror shows 7 before the wrap step.
    checks++;
    if (count !== 3'd7 || ctr_en !== 1'b1) begin
      errors++;
      $display("FAIL wrap_mid: count=%0d en=%b want 7 1", count, ctr_en);
    end
    next_cycle();
    checks++;
    if (count !== 3'd0) begin
      errors++;
      $display("FAIL wrap_to_zero: count=%0d want 0", count);
    end
    run_to_done(en_cnt, cyc, lim, to);
    checks++;
    if (to || en_cnt != 1 || count !== 3'd1 || lim !== 1'b0) begin
      errors++;
      $display("FAIL wrap_done: to=%b en=%0d count=%0d lim=%b want 0 1 1 0",
               to, en_cnt, count, lim);
    end
    next_cycle();
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL wrap_ready: rdy=%b want 1", cmd_ready);
    end
  endtask

  task automatic test_down_saturate();
    int en_cnt, cyc;
    logic lim, to;
    send_cmd(1'b0, 8'd3, 1'b0, 1'b0);
    checks++;
    if (ctr_en !== 1'b1 || ctr_up_down !== 1'b0) begin
      errors++;
      $display("FAIL sat_first: en=%b ud=%b want 1 0", ctr_en, ctr_up_down);
    end
    next_cycle();
    checks++;
    if (count !== 3'd0 || ctr_en !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL sat_blocked: count=%0d en=%b done=%b want 0 0 0", count, ctr_en, done);
    end
    run_to_done(en_cnt, cyc, lim, to);
    checks++;
    if (to || en_cnt != 0 || lim !== 1'b1 || count !== 3'd0) begin
      errors++;
      $display("FAIL sat_done: to=%b en=%0d lim=%b count=%0d want 0 0 1 0",
               to, en_cnt, lim, count);
    end
    next_cycle();
    checks++;
    if (limit_hit !== 1'b0 || ctr_up_down !== 1'b0) begin
      errors++;
      $display("FAIL sat_after: lim=%b ud=%b want 0 0", limit_hit, ctr_up_down);
    end
  endtask

  task automatic test_zero_steps();
    send_cmd(1'b1, 8'd0, 1'b1, 1'b0);
    checks++;
    if (done !== 1'b1 || ctr_en !== 1'b0 || count !== 3'd0 || limit_hit !== 1'b0) begin
      errors++;
      $display("FAIL zero_steps: done=%b en=%b count=%0d lim=%b want 1 0 0 0",
               done, ctr_en, count, limit_hit);
    end
    next_cycle();
    checks++;
    if (cmd_ready !== 1'b1 || count !== 3'd0) begin
      errors++;
      $display("FAIL zero_idle: rdy=%b count=%0d want 1 0", cmd_ready, count);
    end
  endtask

  task automatic test_abort();
    send_cmd(1'b1, 8'd6, 1'b1, 1'b0);
    next_cycle();
    next_cycle();
    abort = 1'b1;
    #1;
    checks++;
    if (ctr_en !== 1'b0 || count !== 3'd2) begin
      errors++;
      $display("FAIL abort_gate: en=%b count=%0d want 0 2", ctr_en, count);
    end
    next_cycle();
    abort = 1'b0;
    checks++;
    if (done !== 1'b1 || limit_hit !== 1'b0 || count !== 3'd2) begin
      errors++;
      $display("FAIL abort_done: done=%b lim=%b count=%0d want 1 0 2", done, limit_hit, count);
    end
    next_cycle();
  endtask

  task automatic test_clear();
    send_cmd(1'b0, 8'd9, 1'b0, 1'b1);
    checks++;
    if (ctr_clr !== 1'b1 || busy !== 1'b1 || ctr_en !== 1'b0 || ctr_up_down !== 1'b1) begin
      errors++;
      $display("FAIL clr_pulse: clr=%b busy=%b en=%b ud=%b want 1 1 0 1",
               ctr_clr, busy, ctr_en, ctr_up_down);
    end
    next_cycle();
    checks++;
    if (ctr_clr !== 1'b0 || done !== 1'b1 || count !== 3'd0) begin
      errors++;
      $display("FAIL clr_done: clr=%b done=%b count=%0d want 0 1 0", ctr_clr, done, count);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_run();
    int done_seen;
    send_cmd(1'b0, 8'd7, 1'b1, 1'b0);
    next_cycle();
    next_cycle();
    // Two wrapping down-steps from 0 give 6; third step is being presented.
    checks++;
    if (count !== 3'd6 || ctr_en !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pre: count=%0d en=%b want 6 1", count, ctr_en);
    end
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    checks++;
    if ({cmd_ready, ctr_en, ctr_up_down, ctr_clr, busy, done, limit_hit} !== 7'b1010000 ||
        count !== 3'd0) begin
      errors++;
      $display("FAIL rst_mid_vals: flags=%b count=%0d want 1010000 0",
               {cmd_ready, ctr_en, ctr_up_down, ctr_clr, busy, done, limit_hit}, count);
    end
    done_seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (done === 1'b1) done_seen++;
      next_cycle();
    end
    checks++;
    if (done_seen != 0) begin
      errors++;
      $display("FAIL rst_mid_no_done: done cycles=%0d want 0", done_seen);
    end
  endtask

  task automatic test_back_to_back();
    int en_cnt, done_cnt, rdy_cnt;
    logic [5:0] en_trace;
    en_cnt   = 0;
    done_cnt = 0;
    rdy_cnt  = 0;
    en_trace = '0;
    cmd_valid = 1'b1;
    cmd_dir   = 1'b1;
    cmd_steps = 8'd1;
    cmd_wrap  = 1'b1;
    cmd_clear = 1'b0;
    // Held valid: accepts at cycles 0 and 3 only (RUN, DONE between).
    for (int i = 1; i <= 5; i++) begin
      next_cycle();
      en_trace[i] = ctr_en;
      if (ctr_en === 1'b1) en_cnt++;
      if (done === 1'b1) done_cnt++;
      if (cmd_ready === 1'b1) rdy_cnt++;
    end
    cmd_valid = 1'b0;
    checks++;
    if (en_trace !== 6'b010010 || done_cnt != 2 || rdy_cnt != 1) begin
      errors++;
      $display("FAIL b2b_trace: en=%b done=%0d rdy=%0d want 010010 2 1",
               en_trace, done_cnt, rdy_cnt);
    end
    next_cycle();
    checks++;
    if (count !== 3'd2 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: count=%0d rdy=%b busy=%b want 2 1 0", count, cmd_ready, busy);
    end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_wrap_around();
    test_down_saturate();
    test_zero_steps();
    test_abort();
    test_clear();
    test_reset_mid_run();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
